dds_sweep: RTL

//  Frequency-sweep (chirp) controller sitting directly upstream of the DDS. Drives the DDS 32-bit

---
 rtl/dds_pkg.sv | 19 +
 rtl/dds_dwell_timer.sv | 47 ++++
 rtl/dds_sweep.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared types for the DDS control blocks.
//   sweep_mode_t  : sweep repeat behaviour selected by the mode input
//   sweep_state_t : sweep controller state
package dds_pkg;

   typedef enum logic [1:0] {
      SWP_SINGLE = 2'd0,
      SWP_SAW    = 2'd1,
      SWP_TRI    = 2'd2,
      SWP_RSVD   = 2'd3
   } sweep_mode_t;

   typedef enum logic [1:0] {
      SWP_IDLE = 2'd0,
      SWP_UP   = 2'd1,
      SWP_DOWN = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: holds off the next update for value+1 cycles after each load.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : restart the timer with value
//   value        : dwell length minus one
//   expire       : registered; high in the last cycle of the dwell period
module dds_dwell_timer #(
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [DWELL_W-1:0] value,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               expire_q, expire_d;

   // expire_q tracks (cnt_q == 0) one cycle ahead so the output is a flop.
   always_comb begin
      cnt_d    = cnt_q;
      expire_d = expire_q;
      if (load) begin
         cnt_d    = value;
         expire_d = (value == '0);
      end else if (cnt_q != '0) begin
         cnt_d    = cnt_q - DWELL_W'(1);
         expire_d = (cnt_q == DWELL_W'(1));
      end else begin
         expire_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_d;
      end
   end

   assign expire = expire_q;

endmodule

// File: rtl/dds_sweep.sv
// Frequency-sweep (chirp) controller driving the DDS phase-step word.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start_freq/stop_freq : sweep end points (unsigned step words)
//   sweep_inc            : step increment per dwell period
//   dwell                : each step value is held dwell+1 cycles
//   mode                 : 0 single, 1 sawtooth, 2 triangle, 3 rejected
//   go / abort           : 1-cycle start / stop strobes
//   step                 : phase step to the DDS, 0 when idle
//   busy                 : sweep in progress
//   done                 : pulse at normal end of a single sweep
//   err                  : pulse when go is rejected
//   sweep_cnt            : completed legs since the last accepted go
module dds_sweep
   import dds_pkg::*;
#(
   parameter int unsigned FW      = 32,
   parameter int unsigned DWELL_W = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [FW-1:0]      start_freq,
   input  logic [FW-1:0]      stop_freq,
   input  logic [FW-1:0]      sweep_inc,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [1:0]         mode,
   input  logic               go,
   input  logic               abort,
   output logic [FW-1:0]      step,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   sweep_cnt
);

   sweep_state_t       state_q, state_d;
   sweep_mode_t        mode_q, mode_d;
   logic [FW-1:0]      start_q, start_d;
   logic [FW-1:0]      stop_q, stop_d;
   logic [FW-1:0]      inc_q, inc_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [FW-1:0]      step_q, step_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               tmr_load;
   logic [DWELL_W-1:0] tmr_value;
   logic               tmr_expire;

   // One extra bit catches carry/borrow so clamping never wraps.
   logic [FW:0] step_add, step_sub, stop_sub, start_add;
   logic        go_valid;

   assign step_add  = {1'b0, step_q}  + {1'b0, inc_q};
   assign step_sub  = {1'b0, step_q}  - {1'b0, inc_q};
   assign stop_sub  = {1'b0, stop_q}  - {1'b0, inc_q};
   assign start_add = {1'b0, start_q} + {1'b0, inc_q};

   assign go_valid = (start_freq <= stop_freq) && (sweep_inc != '0) &&
                     (mode != 2'(SWP_RSVD));

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      start_d   = start_q;
      stop_d    = stop_q;
      inc_d     = inc_q;
      dwell_d   = dwell_q;
      step_d    = step_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      tmr_load  = 1'b0;
      tmr_value = dwell_q;

      case (state_q)
         SWP_IDLE: begin
            // abort in idle swallows a same-cycle go.
            if (go && !abort) begin
               if (go_valid) begin
                  mode_d    = sweep_mode_t'(mode);
                  start_d   = start_freq;
                  stop_d    = stop_freq;
                  inc_d     = sweep_inc;
                  dwell_d   = dwell;
                  step_d    = start_freq;
                  busy_d    = 1'b1;
                  cnt_d     = '0;
                  state_d   = SWP_UP;
                  tmr_load  = 1'b1;
                  tmr_value = dwell;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         SWP_UP: begin
            if (abort) begin
               state_d = SWP_IDLE;
               step_d  = '0;
               busy_d  = 1'b0;
            end else if (tmr_expire) begin
               tmr_load = 1'b1;
               if (step_q == stop_q) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  case (mode_q)
                     SWP_SAW: begin
                        step_d = start_q;
                     end
                     SWP_TRI: begin
                        if (stop_sub[FW] || (stop_sub[FW-1:0] <= start_q)) begin
                           step_d = start_q;
                        end else begin
                           step_d = stop_sub[FW-1:0];
                        end
                        state_d = SWP_DOWN;
                     end
                     default: begin
                        step_d   = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = SWP_IDLE;
                        tmr_load = 1'b0;
                     end
                  endcase
               end else if (step_add >= {1'b0, stop_q}) begin
                  step_d = stop_q;
               end else begin
                  step_d = step_add[FW-1:0];
               end
            end
         end

         SWP_DOWN: begin
            if (abort) begin
               state_d = SWP_IDLE;
               step_d  = '0;
               busy_d  = 1'b0;
            end else if (tmr_expire) begin
               tmr_load = 1'b1;
               if (step_q == start_q) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = SWP_UP;
                  if (start_add >= {1'b0, stop_q}) begin
                     step_d = stop_q;
                  end else begin
                     step_d = start_add[FW-1:0];
                  end
               end else if (step_sub[FW] || (step_sub[FW-1:0] <= start_q)) begin
                  step_d = start_q;
               end else begin
                  step_d = step_sub[FW-1:0];
               end
            end
         end

         default: begin
            state_d = SWP_IDLE;
            step_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SWP_IDLE;
         mode_q  <= SWP_SINGLE;
         start_q <= '0;
         stop_q  <= '0;
         inc_q   <= '0;
         dwell_q <= '0;
         step_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         inc_q   <= inc_d;
         dwell_q <= dwell_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   dds_dwell_timer #(
      .DWELL_W(DWELL_W)
   ) u_dwell_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (tmr_load),
      .value  (tmr_value),
      .expire (tmr_expire)
   );

   assign step      = step_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign sweep_cnt = cnt_q;

endmodule
